// File: rtl/pointer_seq.sv
// Pointer register control sequencer: load/count/output-enable strobes and RD address phase.
// Optional RD post-increment through POST when POINTER_SEQ_AUTOINC_EN is defined.
module pointer_seq #(
  parameter int WAIT_STATES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op,
  input  logic [7:0] op_data,
  output logic [7:0] di,
  output logic       n_we_l,
  output logic       n_we_h,
  output logic       cnt,
  output logic       n_oe_addr,
  output logic       n_oe_dl,
  output logic       n_oe_dh,
  output logic       mem_n_rd,
  input  logic [7:0] mem_di,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       data_stb
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LDW_HI = 3'd1,
    S_STROBE = 3'd2,
    S_MEM    = 3'd3,
    S_POST   = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDL = 3'b001;
  localparam logic [2:0] OP_LDH = 3'b010;
  localparam logic [2:0] OP_LDW = 3'b011;
  localparam logic [2:0] OP_INC = 3'b100;
  localparam logic [2:0] OP_RD  = 3'b101;
  localparam logic [2:0] OP_STL = 3'b110;
  localparam logic [2:0] OP_STH = 3'b111;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;

  logic       op_ready_q, op_ready_d;
  logic [7:0] di_q, di_d;
  logic       n_we_l_q, n_we_l_d;
  logic       n_we_h_q, n_we_h_d;
  logic       cnt_q, cnt_d;
  logic       n_oe_addr_q, n_oe_addr_d;
  logic       n_oe_dl_q, n_oe_dl_d;
  logic       n_oe_dh_q, n_oe_dh_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       data_stb_q, data_stb_d;

  logic accept_s;
  logic mem_last_s;

  assign accept_s   = op_valid && op_ready_q;
  assign mem_last_s = (wait_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (op)
            OP_NOP:  state_d = S_IDLE;
            OP_LDW:  state_d = S_LDW_HI;
            OP_RD: begin
              state_d = S_MEM;
              wait_d  = 4'd0;
            end
            default: state_d = S_STROBE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LDW_HI: begin
        if (accept_s) begin
          state_d = S_STROBE;
        end else begin
          state_d = S_LDW_HI;
        end
      end
      S_MEM: begin
        if (mem_last_s) begin
`ifdef POINTER_SEQ_AUTOINC_EN
          state_d = S_POST;
`else
          state_d = S_STROBE;
`endif
          wait_d  = 4'd0;
        end else begin
          wait_d  = wait_q + 4'd1;
        end
      end
      S_STROBE: state_d = S_IDLE;
      S_POST:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes are computed for the cycle after the transition and then registered.
  always_comb begin
    op_ready_d = (state_d == S_IDLE) || (state_d == S_LDW_HI);
    di_d       = di_q;
    n_we_l_d   = 1'b1;
    n_we_h_d   = 1'b1;
    cnt_d      = 1'b0;
    n_oe_dl_d  = 1'b1;
    n_oe_dh_d  = 1'b1;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    data_stb_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (op)
            OP_LDL, OP_LDW: begin
              n_we_l_d = 1'b0;
              di_d     = op_data;
            end
            OP_LDH: begin
              n_we_h_d = 1'b0;
              di_d     = op_data;
            end
            OP_INC: cnt_d = 1'b1;
            OP_STL: begin
              n_oe_dl_d  = 1'b0;
              data_stb_d = 1'b1;
            end
            OP_STH: begin
              n_oe_dh_d  = 1'b0;
              data_stb_d = 1'b1;
            end
            default: cnt_d = 1'b0;
          endcase
        end else begin
          cnt_d = 1'b0;
        end
      end
      S_LDW_HI: begin
        if (accept_s) begin
          n_we_h_d = 1'b0;
          di_d     = op_data;
        end else begin
          n_we_h_d = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_last_s) begin
          rd_data_d  = mem_di;
          rd_valid_d = 1'b1;
`ifdef POINTER_SEQ_AUTOINC_EN
          cnt_d      = 1'b1;
`endif
        end else begin
          rd_valid_d = 1'b0;
        end
      end
      default: rd_valid_d = 1'b0;
    endcase
    n_oe_addr_d = (state_d != S_MEM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_ready_q  <= 1'b1;
      di_q        <= 8'h00;
      n_we_l_q    <= 1'b1;
      n_we_h_q    <= 1'b1;
      cnt_q       <= 1'b0;
      n_oe_addr_q <= 1'b1;
      n_oe_dl_q   <= 1'b1;
      n_oe_dh_q   <= 1'b1;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      data_stb_q  <= 1'b0;
    end else begin
      op_ready_q  <= op_ready_d;
      di_q        <= di_d;
      n_we_l_q    <= n_we_l_d;
      n_we_h_q    <= n_we_h_d;
      cnt_q       <= cnt_d;
      n_oe_addr_q <= n_oe_addr_d;
      n_oe_dl_q   <= n_oe_dl_d;
      n_oe_dh_q   <= n_oe_dh_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      data_stb_q  <= data_stb_d;
    end
  end

  // Address enable and read strobe share one flop so they can never diverge.
  assign op_ready  = op_ready_q;
  assign di        = di_q;
  assign n_we_l    = n_we_l_q;
  assign n_we_h    = n_we_h_q;
  assign cnt       = cnt_q;
  assign n_oe_addr = n_oe_addr_q;
  assign mem_n_rd  = n_oe_addr_q;
  assign n_oe_dl   = n_oe_dl_q;
  assign n_oe_dh   = n_oe_dh_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign data_stb  = data_stb_q;

endmodule

// File: tb/tb_pointer_seq.sv
// Directed bench for pointer_seq (WAIT_STATES=2) with a behavioural 16-bit pointer register
// and a scoreboard queue of expected read bytes.
module tb_pointer_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] op_data = 8'h00;
  logic [7:0] mem_di = 8'h00;
  logic       op_ready, n_we_l, n_we_h, cnt, n_oe_addr, n_oe_dl, n_oe_dh, mem_n_rd;
  logic       rd_valid, data_stb;
  logic [7:0] di, rd_data;

  logic [15:0] ptr = 16'h0000;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          inv_viol = 0;
  logic [7:0]  exp_q[$];

`ifdef POINTER_SEQ_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  pointer_seq #(.WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .op_data(op_data), .di(di), .n_we_l(n_we_l), .n_we_h(n_we_h), .cnt(cnt),
    .n_oe_addr(n_oe_addr), .n_oe_dl(n_oe_dl), .n_oe_dh(n_oe_dh), .mem_n_rd(mem_n_rd),
    .mem_di(mem_di), .rd_data(rd_data), .rd_valid(rd_valid), .data_stb(data_stb)
  );

  always #5 clk = ~clk;

  // Pointer register downstream of the sequencer.
  always @(posedge clk) begin
    if (cnt) ptr <= ptr + 16'd1;
    else begin
      if (!n_we_l) ptr[7:0]  <= di;
      if (!n_we_h) ptr[15:8] <= di;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if ((!n_oe_dl && !n_oe_dh) || (cnt && (!n_we_l || !n_we_h)) || (n_oe_addr != mem_n_rd))
        inv_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Waits for op_ready, presents one op for one accepting edge, returns in the strobe cycle.
  task automatic send(input logic [2:0] o, input logic [7:0] d);
    for (int i = 0; i < 50 && !op_ready; i++) @(negedge clk);
    if (!op_ready) chk("ready_timeout", {31'd0, op_ready}, 32'd1);
    op_valid = 1'b1;
    op = o;
    op_data = d;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  initial begin
    int lowc;
    int rv_at;
    int rv_seen;
    int stb_pos[$];
    int dl_low;
    int dh_low;
    int dl_at;
    int dh_at;
    logic [7:0] e;

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_act_low", {26'd0, n_we_l, n_we_h, n_oe_addr, n_oe_dl, n_oe_dh, mem_n_rd}, 32'h3f);
    chk("reset_act_high", {29'd0, cnt, rd_valid, data_stb}, 32'd0);
    chk("reset_ready", {31'd0, op_ready}, 32'd1);
    chk("reset_rd_data", {24'd0, rd_data}, 32'h00);
    chk("reset_di", {24'd0, di}, 32'h00);

    // NOP: no strobe, stays ready
    send(3'b000, 8'h77);
    chk("nop_quiet", {28'd0, n_we_l, n_we_h, n_oe_dl, n_oe_dh}, 32'hf);
    chk("nop_ready", {31'd0, op_ready}, 32'd1);

    // LDW 34h then 12h; high-beat opcode is ignored
    send(3'b011, 8'h34);
    chk("ldw_lo_we", {30'd0, n_we_l, n_we_h}, 32'd1);
    chk("ldw_lo_di", {24'd0, di}, 32'h34);
    chk("ldw_mid_ready", {31'd0, op_ready}, 32'd1);
    send(3'b101, 8'h12);
    chk("ldw_hi_we", {30'd0, n_we_l, n_we_h}, 32'd2);
    chk("ldw_hi_di", {24'd0, di}, 32'h12);
    chk("ldw_hi_addr", {31'd0, n_oe_addr}, 32'd1);
    @(negedge clk);
    chk("ldw_ptr", {16'd0, ptr}, 32'h1234);
    chk("di_hold", {24'd0, di}, 32'h12);

    // LDL / LDH single bytes
    send(3'b001, 8'hff);
    chk("ldl_we", {30'd0, n_we_l, n_we_h}, 32'd1);
    send(3'b010, 8'h12);
    chk("ldh_we", {30'd0, n_we_l, n_we_h}, 32'd2);
    @(negedge clk);
    chk("ldlh_ptr", {16'd0, ptr}, 32'h12ff);

    // RD with 2 wait states
    mem_di = 8'ha5;
    exp_q.push_back(8'ha5);
    send(3'b101, 8'h00);
    lowc = 0; rv_at = -1; rv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (!n_oe_addr) lowc++;
      if (rd_valid) begin
        rv_seen = 1;
        rv_at = i;
        e = exp_q.pop_front();
        chk("rd_data", {24'd0, rd_data}, {24'd0, e});
        chk("rd_cnt", {31'd0, cnt}, {31'd0, AUTOINC});
        chk("rd_addr_off", {30'd0, n_oe_addr, mem_n_rd}, 32'd3);
        break;
      end
      @(negedge clk);
    end
    mem_di = 8'h00;
    chk("rd_valid_seen", rv_seen, 32'd1);
    chk("rd_addr_cycles", lowc, 32'd3);
    chk("rd_valid_pos", rv_at, 32'd3);
    @(negedge clk);
    chk("rd_valid_pulse", {31'd0, rd_valid}, 32'd0);
    chk("rd_ptr", {16'd0, ptr}, AUTOINC ? 32'h1300 : 32'h12ff);

    // STL then STH with op_valid held high
    for (int i = 0; i < 50 && !op_ready; i++) @(negedge clk);
    op_valid = 1'b1; op = 3'b110;
    @(negedge clk);
    op = 3'b111;
    dl_low = 0; dh_low = 0; dl_at = -1; dh_at = -1;
    for (int i = 0; i < 6; i++) begin
      if (data_stb) stb_pos.push_back(i);
      if (!n_oe_dl) begin dl_low++; dl_at = i; end
      if (!n_oe_dh) begin dh_low++; dh_at = i; op_valid = 1'b0; end
      @(negedge clk);
    end
    op_valid = 1'b0;
    chk("st_stb_count", stb_pos.size(), 32'd2);
    if (stb_pos.size() == 2) chk("st_stb_gap", stb_pos[1] - stb_pos[0], 32'd2);
    chk("stl_cycles", dl_low, 32'd1);
    chk("sth_cycles", dh_low, 32'd1);
    chk("stl_pos", dl_at, 32'd0);
    chk("sth_pos", dh_at, 32'd2);

    // reset during the 2nd MEM cycle aborts the read
    mem_di = 8'h5a;
    send(3'b101, 8'h00);
    @(negedge clk);
    chk("abort_in_mem", {31'd0, n_oe_addr}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_strobes", {26'd0, n_we_l, n_we_h, n_oe_addr, n_oe_dl, n_oe_dh, mem_n_rd}, 32'h3f);
    chk("abort_ready", {31'd0, op_ready}, 32'd1);
    rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd_valid) rv_seen++;
      @(negedge clk);
    end
    chk("abort_no_rd_valid", rv_seen, 32'd0);
    chk("abort_rd_data", {24'd0, rd_data}, 32'h00);
    mem_di = 8'h00;

    // INC at FFFF wraps
    send(3'b011, 8'hff);
    send(3'b011, 8'hff);
    @(negedge clk);
    chk("inc_pre_ptr", {16'd0, ptr}, 32'hffff);
    send(3'b100, 8'h00);
    chk("inc_cnt", {31'd0, cnt}, 32'd1);
    chk("inc_we_off", {30'd0, n_we_l, n_we_h}, 32'd3);
    @(negedge clk);
    chk("inc_cnt_pulse", {31'd0, cnt}, 32'd0);
    chk("inc_wrap_ptr", {16'd0, ptr}, 32'h0000);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("invariants", inv_viol, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
